// File: rtl/accumulate_main_if.sv
// Call/return bundle for the accumulate kernel: request with loop-carried
// initial values in one direction, result pulse and busy flag in the other.
interface accumulate_main_if #(
  parameter int W = 64
);
  logic         r_enable;
  logic [W-1:0] init_i;
  logic [W-1:0] init_acc;
  logic         w_enable;
  logic [W-1:0] result;
  logic         busy;

  modport master (
    output r_enable,
    output init_i,
    output init_acc,
    input  w_enable,
    input  result,
    input  busy
  );

  modport slave (
    input  r_enable,
    input  init_i,
    input  init_acc,
    output w_enable,
    output result,
    output busy
  );
endinterface

// File: rtl/accumulate_main.sv
// Multi-cycle responder for the accumulate kernel:
//   while (i < LIMIT) { acc = acc + i; i = i + 1; } return acc;
module accumulate_main #(
  parameter int           W     = 64,
  parameter logic [W-1:0] LIMIT = W'(10)
) (
  input  logic               clk,
  input  logic               rst,
  accumulate_main_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    BODY  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] i_q, i_d;
  logic [W-1:0] acc_q, acc_d;
  logic [W-1:0] result_q, result_d;
  logic         w_en_q, w_en_d;
  logic         busy_q, busy_d;
  logic         accept;

  // The result pulse lands in the cycle after DONE, so IDLE refuses a new
  // request while the pulse is still on the wire.
  assign accept = (state_q == IDLE) && bus.r_enable && !w_en_q;

  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    acc_d    = acc_q;
    result_d = result_q;
    w_en_d   = 1'b0;
    busy_d   = busy_q;

    unique case (state_q)
      IDLE: begin
        if (w_en_q) begin
          busy_d = 1'b0;
        end
        if (accept) begin
          i_d     = bus.init_i;
          acc_d   = bus.init_acc;
          busy_d  = 1'b1;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (i_q < LIMIT) begin
          state_d = BODY;
        end else begin
          result_d = acc_q;
          state_d  = DONE;
        end
      end
      BODY: begin
        acc_d   = acc_q + i_q;
        i_d     = i_q + W'(1);
        state_d = CHECK;
      end
      DONE: begin
        w_en_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      i_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      w_en_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      w_en_q   <= w_en_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.w_enable = w_en_q;
  assign bus.result   = result_q;
  assign bus.busy     = busy_q;

endmodule
